// File: rtl/osecpu_core_p.sv
// Multi-cycle OSECPU execution core: request/ack instruction fetch, single-cycle EXEC,
// sticky halt/illegal status and a per-instruction retire strobe.
module osecpu_core_p #(
  parameter int DW   = 32,
  parameter int PCW  = 16,
  parameter int NREG = 64
) (
  input  logic           clk,
  input  logic           reset,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [31:0]    imem_rdata,
  output logic [DW-1:0]  dr,
  output logic [PCW-1:0] pc,
  output logic           halted,
  output logic           illegal,
  output logic           retire
);
  localparam int RIW = $clog2(NREG);

  localparam logic [7:0] OP_LIMM = 8'h02, OP_BNZ = 8'h03, OP_OR  = 8'h10, OP_XOR = 8'h11,
                         OP_AND  = 8'h12, OP_ADD = 8'h14, OP_SUB = 8'h15, OP_CP  = 8'hD2,
                         OP_CPDR = 8'hD3, OP_END = 8'hF0;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  typedef struct packed {
    logic [7:0]     op;
    logic [RIW-1:0] r0;
    logic [RIW-1:0] r1;
    logic [RIW-1:0] r2;
    logic [15:0]    imm;
  } dec_t;

  state_t         state;
  logic [31:0]    ir;
  logic [DW-1:0]  rf [NREG];
  dec_t           d;
  logic [DW-1:0]  va, vb, vs, wdata;
  logic           wr_en, dr_en, known, take;
  logic [PCW-1:0] pc_inc, br_tgt;
  logic           unused_ir;

  assign d.op  = ir[31:24];
  assign d.r0  = ir[18 +: RIW];
  assign d.r1  = ir[12 +: RIW];
  assign d.r2  = ir[6 +: RIW];
  assign d.imm = ir[15:0];
  assign unused_ir = ^ir;

  assign imem_addr = pc;

  // Operand reads see pre-write contents, so rd == ra needs no bypass.
  always_comb begin
    va     = rf[d.r1];
    vb     = rf[d.r2];
    vs     = rf[d.r0];
    wr_en  = 1'b0;
    dr_en  = 1'b0;
    known  = 1'b1;
    wdata  = '0;
    pc_inc = pc + PCW'(1);
    br_tgt = pc_inc + PCW'(signed'(d.imm));
    take   = 1'b0;
    case (d.op)
      OP_LIMM: begin wr_en = 1'b1; wdata = DW'(signed'(d.imm)); end
      OP_CP:   begin wr_en = 1'b1; wdata = va; end
      OP_ADD:  begin wr_en = 1'b1; wdata = va + vb; end
      OP_SUB:  begin wr_en = 1'b1; wdata = va - vb; end
      OP_OR:   begin wr_en = 1'b1; wdata = va | vb; end
      OP_XOR:  begin wr_en = 1'b1; wdata = va ^ vb; end
      OP_AND:  begin wr_en = 1'b1; wdata = va & vb; end
      OP_CPDR: dr_en = 1'b1;
      OP_BNZ:  take = (vs != '0);
      OP_END:  ;
      default: known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      dr       <= '0;
      ir       <= '0;
      imem_req <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      retire   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          imem_req <= 1'b1;
          if (imem_req && imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (d.op == OP_END || !known) begin
            halted  <= 1'b1;
            illegal <= !known;
            state   <= S_HALT;
          end else begin
            if (wr_en) rf[d.r0] <= wdata;
            if (dr_en) dr <= vs;
            pc       <= take ? br_tgt : pc_inc;
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_HALT:  ;
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_osecpu_core_p.sv
// Directed bench for osecpu_core_p: a default-width core with a wait-state memory model,
// plus a DW=16/PCW=4 core for wrap-around cases.
module tb_osecpu_core_p;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, rst_s = 1'b0;
  always #5 clk = ~clk;

  // default-parameter core
  logic        req, ack, halted, illegal, retire;
  logic [15:0] addr, pc;
  logic [31:0] rdata, dr;
  // DW=16, PCW=4 core
  logic        s_req, s_ack, s_halted, s_illegal, s_retire;
  logic [3:0]  s_addr, s_pc;
  logic [31:0] s_rdata;
  logic [15:0] s_dr;

  osecpu_core_p u_dut (
    .clk(clk), .reset(rst_n), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .dr(dr), .pc(pc), .halted(halted), .illegal(illegal), .retire(retire)
  );

  osecpu_core_p #(.DW(16), .PCW(4), .NREG(8)) u_small (
    .clk(clk), .reset(rst_s), .imem_req(s_req), .imem_addr(s_addr), .imem_ack(s_ack),
    .imem_rdata(s_rdata), .dr(s_dr), .pc(s_pc), .halted(s_halted), .illegal(s_illegal),
    .retire(s_retire)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [7:0] op, input int a, input int b, input int c);
    return {op, 6'(a), 6'(b), 6'(c), 6'd0};
  endfunction
  function automatic logic [31:0] li(input int rd, input logic [15:0] imm);
    return {8'h02, 6'(rd), 2'b00, imm};
  endfunction
  function automatic logic [31:0] bnz(input int rs, input logic [15:0] imm);
    return {8'h03, 6'(rs), 2'b00, imm};
  endfunction
  localparam logic [31:0] I_END = 32'hF000_0000;

  // memory model with programmable wait states
  logic [31:0] mem [64];
  int          wait_n = 0, wcnt = 0, stab_err = 0;
  int          fetch_cnt [64];
  logic [15:0] a_addr;

  initial begin
    ack = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (req && rst_n) begin
        if (wcnt == 0) a_addr = addr;
        else if (addr != a_addr) stab_err++;
        if (wcnt == wait_n) begin
          ack = 1'b1; rdata = mem[addr[5:0]]; fetch_cnt[addr[5:0]]++; wcnt = 0;
        end else begin
          ack = 1'b0; wcnt++;
        end
      end else begin
        ack = 1'b0; wcnt = 0;
      end
    end
  end

  // retire / dr trace monitor
  int          cyc = 0, n_ret = 0, first_ret = -1, last_ret = -1;
  logic [31:0] dr_prev = '0;
  logic [31:0] drq [$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (retire) begin
        n_ret++;
        last_ret = cyc;
        if (first_ret < 0) first_ret = cyc;
      end
      if (dr != dr_prev) begin drq.push_back(dr); dr_prev = dr; end
    end
  end

  // small core: zero-wait memory and dr trace
  logic [31:0] mem_s [16];
  logic [15:0] s_dr_prev = '0;
  logic [15:0] s_drq [$];

  initial begin
    s_ack = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      s_ack = s_req && rst_s;
      s_rdata = mem_s[s_addr];
      if (rst_s && s_dr != s_dr_prev) begin s_drq.push_back(s_dr); s_dr_prev = s_dr; end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin mem[i] = I_END; fetch_cnt[i] = 0; end
  endtask

  task automatic start(input int wn);
    rst_n = 1'b0;
    @(negedge clk);
    wait_n = wn; stab_err = 0; n_ret = 0; first_ret = -1; last_ret = -1;
    dr_prev = '0; drq.delete();
    for (int i = 0; i < 64; i++) fetch_cnt[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    chk({tag, "_halted"}, halted, 1);
  endtask

  task automatic load_arith();
    clear_mem();
    mem[0]  = li(1, 16'd5);
    mem[1]  = li(2, 16'd7);
    mem[2]  = rr(8'h14, 3, 1, 2);
    mem[3]  = rr(8'h15, 4, 1, 2);
    mem[4]  = rr(8'hD3, 3, 0, 0);
    mem[5]  = rr(8'hD3, 4, 0, 0);
    mem[6]  = rr(8'h12, 5, 1, 2);
    mem[7]  = rr(8'h10, 6, 1, 2);
    mem[8]  = rr(8'h11, 7, 1, 2);
    mem[9]  = rr(8'hD2, 8, 7, 0);
    mem[10] = rr(8'hD3, 5, 0, 0);
    mem[11] = rr(8'hD3, 6, 0, 0);
    mem[12] = rr(8'hD3, 8, 0, 0);
  endtask

  task automatic check_arith(input string tag, input int cpi);
    logic [31:0] exp_dr [5];
    exp_dr = '{32'hC, 32'hFFFF_FFFE, 32'h5, 32'h7, 32'h2};
    chk({tag, "_pc"}, pc, 13);
    chk({tag, "_retires"}, n_ret, 13);
    chk({tag, "_drq_len"}, drq.size(), 5);
    for (int i = 0; i < 5 && i < drq.size(); i++) chk({tag, "_dr_seq"}, drq[i], exp_dr[i]);
    chk({tag, "_cpi"}, last_ret - first_ret, cpi * 12);
    chk({tag, "_addr_stable"}, stab_err, 0);
  endtask

  initial begin
    int k;
    // reset state and first-instruction latency
    clear_mem();
    mem[0] = li(1, 16'h8000);
    mem[1] = rr(8'hD3, 1, 0, 0);
    wait_n = 0;
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_dr", dr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retire", retire, 0);
    rst_n = 1'b1;
    k = 0;
    while (!req && k < 10) begin @(negedge clk); k++; end
    chk("first_req", req, 1);
    chk("first_addr", addr, 0);
    @(negedge clk);
    chk("no_early_retire", retire, 0);
    @(negedge clk);
    chk("first_retire", retire, 1);
    chk("first_pc", pc, 1);
    wait_halt("limm", 50);
    chk("limm_sext_dr", dr, 32'hFFFF_8000);
    chk("limm_pc", pc, 2);

    // arithmetic and logic, zero wait then four wait states
    load_arith();
    start(0);
    wait_halt("arith0", 200);
    check_arith("arith0", 2);
    start(4);
    wait_halt("arith4", 500);
    check_arith("arith4", 6);

    // countdown loop, END at address 5
    clear_mem();
    mem[0] = li(1, 16'd3);
    mem[1] = li(2, 16'd1);
    mem[2] = rr(8'h15, 1, 1, 2);
    mem[3] = bnz(1, 16'hFFFE);
    mem[4] = rr(8'hD3, 2, 0, 0);
    start(0);
    wait_halt("loop", 200);
    chk("loop_body_count", fetch_cnt[2], 3);
    chk("loop_bnz_count", fetch_cnt[3], 3);
    chk("loop_retires", n_ret, 9);
    chk("loop_dr", dr, 1);
    repeat (5) @(negedge clk);
    chk("end_pc", pc, 5);
    chk("end_illegal", illegal, 0);
    chk("end_req_low", req, 0);
    chk("end_fetch_once", fetch_cnt[5], 1);
    chk("end_halted_sticky", halted, 1);

    // illegal opcode
    clear_mem();
    mem[0] = li(1, 16'd1);
    mem[1] = 32'h7700_0000;
    start(0);
    wait_halt("ill", 50);
    chk("ill_flag", illegal, 1);
    chk("ill_pc", pc, 1);
    chk("ill_retires", n_ret, 1);

    // asynchronous reset in the middle of a wait-state fetch
    clear_mem();
    mem[0] = li(1, 16'd9);
    mem[1] = rr(8'hD3, 1, 0, 0);
    mem[2] = li(2, 16'd4);
    start(4);
    k = 0;
    while (dr != 32'd9 && k < 100) begin @(negedge clk); k++; end
    chk("mid_dr", dr, 9);
    @(negedge clk);
    chk("mid_req", req, 1);
    chk("mid_pc", pc, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", req, 0);
    chk("async_pc", pc, 0);
    chk("async_dr", dr, 0);
    chk("async_retire", retire, 0);

    // DW=16 / PCW=4: ADD wraps to zero, BNZ at 15 wraps pc to 0
    for (int i = 0; i < 16; i++) mem_s[i] = I_END;
    mem_s[0]  = li(1, 16'd1);
    mem_s[1]  = li(2, 16'hFFFF);
    mem_s[2]  = rr(8'h14, 3, 2, 1);
    mem_s[3]  = rr(8'hD3, 2, 0, 0);
    mem_s[4]  = rr(8'hD3, 3, 0, 0);
    mem_s[5]  = bnz(1, 16'd9);
    mem_s[15] = bnz(1, 16'd0);
    @(negedge clk);
    rst_s = 1'b1;
    k = 0;
    while (s_pc != 4'd15 && k < 100) begin @(negedge clk); k++; end
    chk("s_reach15", s_pc, 15);
    mem_s[0] = I_END;
    k = 0;
    while (!s_halted && k < 100) begin @(negedge clk); k++; end
    chk("s_halted", s_halted, 1);
    chk("s_pc_wrap", s_pc, 0);
    chk("s_illegal", s_illegal, 0);
    chk("s_drq_len", s_drq.size(), 2);
    if (s_drq.size() == 2) begin
      chk("s_dr_ffff", s_drq[0], 16'hFFFF);
      chk("s_add_wrap", s_drq[1], 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
